pts_sr_8_ctrl: RTL and testbench

- 8-word parallel-to-serial output stage for the SHA core.
- Captures a 256-bit hash or block in one cycle, then streams it out one 32-bit word per accepted transfer over a valid/ready handshake.
- It is the transmit-side counterpart of the 8-word serial-to-parallel collector; it feeds the downstream interface or another core one word at a time.

---
 rtl/sha_pkg.sv | 16 +
 rtl/pts_sr.sv | 41 ++++
 rtl/pts_sr_8_ctrl.sv | 94 +++++++++
 tb/tb_pts_sr_8_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Types and constants shared by the SHA core, the serial-to-parallel collector
// and the parallel-to-serial output stage.
package sha_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;

  typedef logic [WORD_W-1:0]          hash_word_t;
  typedef hash_word_t [NUM_WORDS-1:0] hash_frame_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } pts_state_e;

endpackage : sha_pkg

// File: rtl/pts_sr.sv
// Generic word-wide parallel-to-serial shift register. The head word sits in
// the top slot; each shift moves the frame one word toward the head, zero-filling.
module pts_sr #(
  parameter int NUM_WORDS = 8,
  parameter int WORD_W    = 32
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        load_enable,
  input  logic                        shift_enable,
  input  logic [NUM_WORDS*WORD_W-1:0] parallel_in,
  output logic [WORD_W-1:0]           serial_out
);

  localparam int FRAME_W = NUM_WORDS * WORD_W;

  logic [FRAME_W-1:0] data_q, data_d;

  // Load wins over shift so a frame can be captured on the final transfer.
  always_comb begin
    data_d = data_q;
    if (load_enable) begin
      data_d = parallel_in;
    end else if (shift_enable) begin
      data_d = data_q << WORD_W;
    end
  end

  // NOTE: the frame buffer is deliberately reset; serial_out must read zero
  // out of reset, and that output is taken straight from this register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign serial_out = data_q[FRAME_W-1 -: WORD_W];

endmodule : pts_sr

// File: rtl/pts_sr_8_ctrl.sv
// 8-word parallel-to-serial output stage: captures a whole frame in one cycle
// and streams it one word per valid/ready transfer, with zero-bubble reload.
module pts_sr_8_ctrl
  import sha_pkg::*;
#(
  parameter int NUM_WORDS = sha_pkg::NUM_WORDS,
  parameter int WORD_W    = sha_pkg::WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        load_enable,
  input  logic [NUM_WORDS*WORD_W-1:0] parallel_in,
  output logic                        load_ready,
  output logic [WORD_W-1:0]           serial_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  pts_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               xfer, load;
  logic [NUM_WORDS*WORD_W-1:0] frame_ordered;

  // The shift register always emits its top word first, so LSB-first frames
  // are word-reversed on the way in.
  always_comb begin
    frame_ordered = parallel_in;
    if (!MSB_FIRST) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        frame_ordered[(NUM_WORDS-1-i)*WORD_W +: WORD_W] = parallel_in[i*WORD_W +: WORD_W];
      end
    end
  end

  assign out_valid  = (state_q == ST_SHIFT);
  assign busy       = (state_q == ST_SHIFT);
  assign out_last   = out_valid && (cnt_q == LAST_IDX);
  assign load_ready = (state_q == ST_IDLE) || (out_last && out_ready);
  assign xfer       = out_valid && out_ready;
  assign load       = load_enable && load_ready;
  assign done       = done_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = xfer && out_last;
    if (load) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
    end else if (xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (out_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  pts_sr #(
    .NUM_WORDS (NUM_WORDS),
    .WORD_W    (WORD_W)
  ) u_pts_sr (
    .clk          (clk),
    .n_rst        (n_rst),
    .load_enable  (load),
    .shift_enable (xfer),
    .parallel_in  (frame_ordered),
    .serial_out   (serial_out)
  );

endmodule : pts_sr_8_ctrl

// File: tb/tb_pts_sr_8_ctrl.sv
// Directed bench for pts_sr_8_ctrl: MSB-first and LSB-first instances, with
// backpressure, back-to-back frames, ignored loads and asynchronous reset.
module tb_pts_sr_8_ctrl;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         load_enable, load_enable_l;
  logic [255:0] parallel_in, parallel_in_l;
  logic         out_ready, out_ready_l;
  logic         load_ready, load_ready_l;
  logic [31:0]  serial_out, serial_out_l;
  logic         out_valid, out_valid_l;
  logic         out_last, out_last_l;
  logic         busy, busy_l;
  logic         done, done_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pts_sr_8_ctrl #(.MSB_FIRST(1'b1)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_enable (load_enable),
    .parallel_in (parallel_in),
    .load_ready  (load_ready),
    .serial_out  (serial_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  pts_sr_8_ctrl #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_enable (load_enable_l),
    .parallel_in (parallel_in_l),
    .load_ready  (load_ready_l),
    .serial_out  (serial_out_l),
    .out_valid   (out_valid_l),
    .out_ready   (out_ready_l),
    .out_last    (out_last_l),
    .busy        (busy_l),
    .done        (done_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word i of the frame (bits [32*i+31:32*i]) is base+i.
  function automatic logic [255:0] make_frame(input logic [31:0] base);
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = base + 32'(i);
    return f;
  endfunction

  // Streams an MSB-first frame with out_ready held high: base+7 down to base+0.
  task automatic stream_frame(input logic [31:0] base, input string tag, input bit first_done);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_valid%0d", tag, k), {31'd0, out_valid}, 32'd1);
      check($sformatf("%s_word%0d", tag, k), serial_out, base + 32'(7 - k));
      check($sformatf("%s_last%0d", tag, k), {31'd0, out_last}, {31'd0, k == 7});
      check($sformatf("%s_done%0d", tag, k), {31'd0, done}, {31'd0, (k == 0) && first_done});
      tick();
    end
  endtask

  initial begin
    int idx;

    n_rst         = 1'b0;
    load_enable   = 1'b0;
    parallel_in   = '0;
    out_ready     = 1'b0;
    load_enable_l = 1'b0;
    parallel_in_l = '0;
    out_ready_l   = 1'b0;

    // Reset and idle
    #12;
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_serial_out", serial_out, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_lsb_serial_out", serial_out_l, 32'd0);
    #5 n_rst = 1'b1;
    tick();
    check("idle_load_ready", {31'd0, load_ready}, 32'd1);
    check("idle_out_last", {31'd0, out_last}, 32'd0);

    // Basic frame, out_ready always high
    parallel_in = make_frame(32'h0);
    load_enable = 1'b1;
    out_ready   = 1'b1;
    check("s1_valid_before_load", {31'd0, out_valid}, 32'd0);
    tick();
    load_enable = 1'b0;
    stream_frame(32'h0, "s1", 1'b0);
    check("s1_done", {31'd0, done}, 32'd1);
    check("s1_idle_valid", {31'd0, out_valid}, 32'd0);
    check("s1_idle_last", {31'd0, out_last}, 32'd0);
    check("s1_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    check("s1_done_clear", {31'd0, done}, 32'd0);

    // Backpressure: out_ready pattern 1,0,0,1,0,0,...
    load_enable = 1'b1;
    tick();
    load_enable = 1'b0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      check($sformatf("s2_word_c%0d", c), serial_out, 32'(7 - idx));
      check($sformatf("s2_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("s2_done_c%0d", c), {31'd0, done}, 32'd0);
      out_ready = (c % 3 == 0);
      tick();
      if (out_ready) idx++;
    end
    check("s2_transfers", 32'(idx), 32'd8);
    check("s2_done", {31'd0, done}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("s2_done_clear", {31'd0, done}, 32'd0);

    // Back-to-back: frame B loaded on frame A's final transfer
    parallel_in = make_frame(32'h0);
    load_enable = 1'b1;
    tick();
    load_enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("s3a_word%0d", k), serial_out, 32'(7 - k));
      tick();
    end
    check("s3a_word7", serial_out, 32'd0);
    check("s3a_last", {31'd0, out_last}, 32'd1);
    parallel_in = make_frame(32'hB0);
    load_enable = 1'b1;
    #1;
    check("s3_load_ready_on_last", {31'd0, load_ready}, 32'd1);
    tick();
    load_enable = 1'b0;
    check("s3_no_gap_busy", {31'd0, busy}, 32'd1);
    stream_frame(32'hB0, "s3b", 1'b1);
    check("s3b_done", {31'd0, done}, 32'd1);
    tick();

    // Load request mid-frame is ignored
    parallel_in = make_frame(32'hC0);
    load_enable = 1'b1;
    tick();
    load_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("s4_word%0d", k), serial_out, 32'hC0 + 32'(7 - k));
      tick();
    end
    parallel_in = make_frame(32'hD0);
    for (int k = 3; k < 8; k++) begin
      load_enable = (k < 7);
      #1;
      check($sformatf("s4_load_ready%0d", k), {31'd0, load_ready}, {31'd0, k == 7});
      check($sformatf("s4_word%0d", k), serial_out, 32'hC0 + 32'(7 - k));
      tick();
    end
    load_enable = 1'b0;
    check("s4_done", {31'd0, done}, 32'd1);
    check("s4_idle_valid", {31'd0, out_valid}, 32'd0);
    tick();

    // Asynchronous reset after four accepted words
    parallel_in = make_frame(32'hE0);
    load_enable = 1'b1;
    tick();
    load_enable = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("s5_word_before_rst", serial_out, 32'hE3);
    #3 n_rst = 1'b0;
    #1;
    check("s5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("s5_rst_busy", {31'd0, busy}, 32'd0);
    check("s5_rst_serial_out", serial_out, 32'd0);
    check("s5_rst_load_ready", {31'd0, load_ready}, 32'd1);
    #2 n_rst = 1'b1;
    tick();
    check("s5_no_done", {31'd0, done}, 32'd0);
    check("s5_idle_valid", {31'd0, out_valid}, 32'd0);
    parallel_in = make_frame(32'h10);
    load_enable = 1'b1;
    tick();
    load_enable = 1'b0;
    stream_frame(32'h10, "s5b", 1'b0);
    check("s5b_done", {31'd0, done}, 32'd1);
    tick();

    // LSB-first instance: 0xA0 out first
    parallel_in_l = make_frame(32'hA0);
    load_enable_l = 1'b1;
    out_ready_l   = 1'b1;
    tick();
    load_enable_l = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("s6_valid%0d", k), {31'd0, out_valid_l}, 32'd1);
      check($sformatf("s6_word%0d", k), serial_out_l, 32'hA0 + 32'(k));
      check($sformatf("s6_last%0d", k), {31'd0, out_last_l}, {31'd0, k == 7});
      tick();
    end
    check("s6_done", {31'd0, done_l}, 32'd1);
    tick();
    check("s6_done_clear", {31'd0, done_l}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pts_sr_8_ctrl
